// File: rtl/fp_div_seq_pkg.sv
// Shared fixed-point helpers: FSM state type, Q-format width helpers and
// saturation patterns used by the divider and the multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } fp_div_state_e;

  function automatic int unsigned fp_word_w(input int unsigned i, input int unsigned f);
    return i + f;
  endfunction

  function automatic int unsigned fp_div_num_w(input int unsigned i1, input int unsigned out_f,
                                               input int unsigned f2);
    return i1 + out_f + f2;
  endfunction

  function automatic int unsigned fp_div_shift(input int unsigned out_f, input int unsigned f2,
                                               input int unsigned f1);
    return out_f + f2 - f1;
  endfunction

  // Largest representable value of a w-bit word; signed gives 0x7F.., unsigned all ones.
  function automatic logic [63:0] fp_sat_max(input int unsigned w, input logic sgn);
    return sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
  endfunction

  // Bit pattern of -2^(w-1); also the magnitude limit for negative results.
  function automatic logic [63:0] fp_sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/done handshake, operands and result flags of the sequential divider.
interface fp_div_seq_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned BW = 6,
  parameter int unsigned OW = 8
);
  logic          start;
  logic          sign;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          busy;
  logic          done;
  logic [OW-1:0] out;
  logic          overflow;
  logic          underflow;
  logic          div_by_zero;

  modport master (
    output start, sign, a, b,
    input  busy, done, out, overflow, underflow, div_by_zero
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, out, overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/fp_div_seq_step.sv
// One restoring division step: shift in a numerator bit, subtract the divisor if it fits.
module fp_div_step #(
  parameter int unsigned DW = 6
) (
  input  logic [DW-1:0] rem_in,
  input  logic          num_bit,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_out,
  output logic          q_bit
);
  logic [DW:0] trial;

  // rem_in < divisor, so both the difference and a non-subtracted trial fit in DW bits.
  always_comb begin
    trial   = {rem_in, num_bit};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? DW'(trial - {1'b0, divisor}) : DW'(trial);
  end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential restoring fixed-point divider, one quotient bit per cycle, saturating.
// Optional macro FP_DIV_ROUND_NEAREST_EN: extra guard step, round half away from zero.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int unsigned I1    = 3,
  parameter int unsigned F1    = 2,
  parameter int unsigned I2    = 4,
  parameter int unsigned F2    = 2,
  parameter int unsigned OUT_I = 5,
  parameter int unsigned OUT_F = 3
) (
  input logic        clk,
  input logic        rst_n,
  fp_div_seq_if.slave bus
);
  localparam int unsigned AW = fp_word_w(I1, F1);
  localparam int unsigned BW = fp_word_w(I2, F2);
  localparam int unsigned W  = fp_word_w(OUT_I, OUT_F);
  localparam int unsigned N  = fp_div_num_w(I1, OUT_F, F2);
  localparam int unsigned SH = fp_div_shift(OUT_F, F2, F1);
`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int unsigned G  = 1;
`else
  localparam int unsigned G  = 0;
`endif
  localparam int unsigned NS   = N + G;
  localparam int unsigned QW   = N + 1;
  localparam int unsigned CW   = (QW > W + 1) ? QW : W + 1;
  localparam int unsigned CNTW = $clog2(NS + 1);

  fp_div_state_e   state, state_next;
  logic            load, step, fix;

  logic            sign_r, neg_r, a_neg_r, dbz_r;
  logic [BW-1:0]   dvs, rem, rem_nx;
  logic            q_bit;
  logic [NS-1:0]   num, q, num_init;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0]   abs_a;
  logic [BW-1:0]   abs_b;

  logic [QW-1:0]   q_mag;
  logic            inexact;
  logic [CW-1:0]   lim;
  logic            ovf_c;
  logic            sat_neg;
  logic [W-1:0]    q_low, out_c, out_sat;

  logic [W-1:0]    out_r;
  logic            done_r, ovf_r, udf_r, dbz_o;

  always_comb begin
    abs_a    = (bus.sign && bus.a[AW-1]) ? -bus.a : bus.a;
    abs_b    = (bus.sign && bus.b[BW-1]) ? -bus.b : bus.b;
    num_init = NS'(abs_a) << (SH + G);
  end

  fp_div_step #(.DW(BW)) u_step (
    .rem_in  (rem),
    .num_bit (num[NS-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        load       = 1'b1;
        state_next = (bus.b == '0) ? FIX : DIV;
      end
      DIV: begin
        step = 1'b1;
        if (cnt == CNTW'(NS - 1)) state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result formation: optional rounding, range check against the signed/unsigned limit.
  always_comb begin
`ifdef FP_DIV_ROUND_NEAREST_EN
    q_mag   = QW'(q[NS-1:1]) + QW'(q[0]);
    inexact = (rem != '0) || q[0];
`else
    q_mag   = QW'(q);
    inexact = (rem != '0);
`endif
    lim     = neg_r ? CW'(fp_sat_min(W)) : CW'(fp_sat_max(W, sign_r));
    ovf_c   = (CW'(q_mag) > lim);
    q_low   = W'(q_mag);
    out_c   = neg_r ? -q_low : q_low;
    sat_neg = dbz_r ? a_neg_r : neg_r;
    out_sat = sat_neg ? W'(fp_sat_min(W)) : W'(fp_sat_max(W, sign_r));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      neg_r   <= 1'b0;
      a_neg_r <= 1'b0;
      dbz_r   <= 1'b0;
      dvs     <= '0;
      rem     <= '0;
      num     <= '0;
      q       <= '0;
      cnt     <= '0;
      out_r   <= '0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
      dbz_o   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load) begin
        sign_r  <= bus.sign;
        neg_r   <= bus.sign & (bus.a[AW-1] ^ bus.b[BW-1]);
        a_neg_r <= bus.sign & bus.a[AW-1];
        dbz_r   <= (bus.b == '0);
        dvs     <= abs_b;
        rem     <= '0;
        num     <= num_init;
        q       <= '0;
        cnt     <= '0;
      end
      if (step) begin
        rem <= rem_nx;
        q   <= {q[NS-2:0], q_bit};
        num <= num << 1;
        cnt <= cnt + 1'b1;
      end
      if (fix) begin
        done_r <= 1'b1;
        dbz_o  <= dbz_r;
        if (dbz_r || ovf_c) begin
          out_r <= out_sat;
          ovf_r <= 1'b1;
          udf_r <= 1'b0;
        end else begin
          out_r <= out_c;
          ovf_r <= 1'b0;
          udf_r <= inexact;
        end
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.out         = out_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = udf_r;
  assign bus.div_by_zero = dbz_o;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, random ops against a rational model.
module tb_fp_div_seq;
  localparam int unsigned I1 = 3, F1 = 2, I2 = 4, F2 = 2, OUT_I = 5, OUT_F = 3;
  localparam int unsigned AW = I1 + F1;
  localparam int unsigned BW = I2 + F2;
  localparam int unsigned W  = OUT_I + OUT_F;
  localparam int unsigned N  = I1 + OUT_F + F2;
`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int LAT = N + 2;
  localparam logic [W-1:0] ROUND_EXP = 8'd35;
`else
  localparam int LAT = N + 1;
  localparam logic [W-1:0] ROUND_EXP = 8'd34;
`endif
  localparam int MAXWAIT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp_div_seq_if #(.AW(AW), .BW(BW), .OW(W)) bus ();

  fp_div_seq #(.I1(I1), .F1(F1), .I2(I2), .F2(F2), .OUT_I(OUT_I), .OUT_F(OUT_F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact rational quotient a/b scaled by 2^OUT_F, with integer arithmetic.
  function automatic logic [W+2:0] model(input logic s, input logic [AW-1:0] a,
                                          input logic [BW-1:0] b);
    longint av, bv, num, den, q, r, pos, nmin, lim;
    logic   neg;
    if (s) begin
      av = longint'($signed(a));
      bv = longint'($signed(b));
    end else begin
      av = longint'(a);
      bv = longint'(b);
    end
    pos  = s ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    nmin = longint'(1) << (W - 1);
    if (bv == 0) return {(s && av < 0) ? W'(nmin) : W'(pos), 3'b101};
    neg = s && ((av < 0) != (bv < 0));
    num = (av < 0 ? -av : av) << (OUT_F + F2);
    den = (bv < 0 ? -bv : bv) << F1;
    q   = num / den;
    r   = num % den;
`ifdef FP_DIV_ROUND_NEAREST_EN
    if (2 * r >= den) q = q + 1;
`endif
    lim = neg ? nmin : pos;
    if (q > lim) return {neg ? W'(nmin) : W'(pos), 3'b100};
    return {neg ? W'(-q) : W'(q), 1'b0, (r != 0), 1'b0};
  endfunction

  function automatic logic [W+2:0] got_res();
    return {bus.out, bus.overflow, bus.underflow, bus.div_by_zero};
  endfunction

  task automatic run_op(input logic s, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= MAXWAIT && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.sign = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy, bus.done});
    end
    n_cmp++;
    if (got_res() !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", got_res());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic            ts [6];
    logic [AW-1:0]   ta [6];
    logic [BW-1:0]   tb [6];
    logic [W+2:0]    te [6];
    int              tl [6];
    int              lat;
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ta = '{5'b01101, 5'b11000, 5'b10000, 5'b10000, 5'b00100, 5'b01101};
    tb = '{6'b000110, 6'b000010, 6'b111111, 6'b000001, 6'b000000, 6'b000011};
    te = '{{8'h11, 3'b010}, {8'hE0, 3'b000}, {8'h7F, 3'b100}, {8'h80, 3'b000},
           {8'h7F, 3'b101}, {ROUND_EXP, 3'b010}};
    tl = '{LAT, LAT, LAT, LAT, 1, LAT};
    for (int i = 0; i < 6; i++) begin
      run_op(ts[i], ta[i], tb[i], lat);
      n_cmp++;
      if (lat != tl[i]) begin
        n_bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, tl[i]);
      end
      n_cmp++;
      if (got_res() !== te[i]) begin
        n_bad++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, got_res(), te[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.done, got_res()} !== {1'b0, te[i]}) begin
        n_bad++; $display("FAIL directed_hold[%0d] got=%h exp=%h", i, {bus.done, got_res()},
                          {1'b0, te[i]});
      end
    end
  endtask

  task automatic test_random();
    logic          s;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [W+2:0]  e;
    int            lat;
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      b = ($urandom_range(0, 9) == 0) ? '0 : BW'($urandom);
      e = model(s, a, b);
      run_op(s, a, b, lat);
      n_cmp++;
      if (lat != ((b == '0) ? 1 : LAT)) begin
        n_bad++; $display("FAIL random_latency s=%b a=%b b=%b got=%0d", s, a, b, lat);
      end
      n_cmp++;
      if (got_res() !== e) begin
        n_bad++; $display("FAIL random_result s=%b a=%b b=%b got=%h exp=%h", s, a, b, got_res(), e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 5'b01101; bus.b = 6'b000110;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_after_start got=%b exp=1", bus.busy);
    end
    lat = -1;
    for (int k = 1; k <= MAXWAIT && lat < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.start = 1'b1; bus.sign = 1'b1; bus.a = 5'b10000; bus.b = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) lat = k;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (lat != LAT) begin
      n_bad++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, LAT);
    end
    n_cmp++;
    if (got_res() !== model(1'b0, 5'b01101, 6'b000110)) begin
      n_bad++; $display("FAIL busy_ignore_result got=%h exp=%h", got_res(),
                        model(1'b0, 5'b01101, 6'b000110));
    end
  endtask

  task automatic test_reset_abort();
    int seen, lat;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b1; bus.a = 5'b11000; bus.b = 6'b000011;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.busy, bus.done, got_res()} !== '0) begin
      n_bad++; $display("FAIL abort_outputs got=%h exp=0", {bus.busy, bus.done, got_res()});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abort_no_done got=%0d exp=0", seen);
    end
    run_op(1'b1, 5'b11000, 6'b000011, lat);
    n_cmp++;
    if (lat != LAT || got_res() !== model(1'b1, 5'b11000, 6'b000011)) begin
      n_bad++; $display("FAIL abort_recover lat=%0d got=%h exp=%h", lat, got_res(),
                        model(1'b1, 5'b11000, 6'b000011));
    end
  endtask

  task automatic test_back_to_back();
    logic          s;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    int            lat;
    for (int i = 0; i < 4; i++) begin
      s = 1'(i);
      a = AW'($urandom);
      b = BW'($urandom_range(1, (1 << BW) - 1));
      run_op(s, a, b, lat);
      n_cmp++;
      if (lat != LAT || got_res() !== model(s, a, b)) begin
        n_bad++; $display("FAIL back_to_back[%0d] lat=%0d got=%h exp=%h", i, lat, got_res(),
                          model(s, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired after 2ms");
    $fatal(1);
  end

endmodule
